// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared types and constants for the pipeline hazard controller:
//   - mw_state_e : state encoding of the sram-like transaction wait FSM
//                  (used for both the instruction and data side)
//   - FWD_*      : operand forward-select codes driven on forwardAE/forwardBE
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

    typedef enum logic {
        MW_IDLE = 1'b0,   // no transaction outstanding past its address phase
        MW_WAIT = 1'b1    // address accepted, waiting for data_ok
    } mw_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;  // operand from writeback stage
    localparam logic [1:0] FWD_M  = 2'b10;  // operand from memory stage

endpackage

// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
// Bundles every signal exchanged between the pipeline and the hazard unit.
//   master : the pipeline side (drives register numbers, stage control,
//            memory handshakes, exception; receives forward/stall/flush)
//   slave  : the hazard unit
// Parameter REGW is the register-number width.
// -----------------------------------------------------------------------------
interface hazard_unit_if #(
    parameter int REGW = 5
);
    // Register numbers
    logic [REGW-1:0] rsD, rtD, rsE, rtE;
    logic [REGW-1:0] writeregE, writeregM, writeregW;

    // Stage control
    logic regwriteE, regwriteM, regwriteW;
    logic memtoregE, memtoregM;
    logic branchD, jrD;
    logic div_busyE, div_readyE;

    // sram-like handshakes toward the AXI bridge
    logic inst_req, inst_addr_ok, inst_data_ok;
    logic data_req, data_addr_ok, data_data_ok;

    logic exceptionM;

    // Results
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushD, flushE, flushM, flushW;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jrD, div_busyE, div_readyE,
               inst_req, inst_addr_ok, inst_data_ok,
               data_req, data_addr_ok, data_data_ok, exceptionM,
        input  forwardAD, forwardBD, forwardAE, forwardBE,
               stallF, stallD, stallE, stallM, stallW,
               flushD, flushE, flushM, flushW
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jrD, div_busyE, div_readyE,
               inst_req, inst_addr_ok, inst_data_ok,
               data_req, data_addr_ok, data_data_ok, exceptionM,
        output forwardAD, forwardBD, forwardAE, forwardBE,
               stallF, stallD, stallE, stallM, stallW,
               flushD, flushE, flushM, flushW
    );

endinterface

// File: rtl/hazard_unit_mem_wait_fsm.sv
// -----------------------------------------------------------------------------
// mem_wait_fsm
// Tracks one outstanding sram-like transaction and raises stall while the
// pipeline must wait for its data.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request presented this cycle
//   addr_ok  : address phase accepted
//   data_ok  : data phase complete
//   stall    : transaction in flight and data not yet returned (combinational)
// A data_ok together with addr_ok finishes the access with no wait state.
// -----------------------------------------------------------------------------
module mem_wait_fsm
    import hazard_unit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic addr_ok,
    input  logic data_ok,
    output logic stall
);

    mw_state_e state_q, state_d;

    always_comb begin
        // NOTE: default assignment first so every path drives state_d; no latch.
        state_d = state_q;
        case (state_q)
            MW_IDLE: if (req && addr_ok && !data_ok) state_d = MW_WAIT;
            MW_WAIT: if (data_ok)                    state_d = MW_IDLE;
        endcase
    end

    // Stall must react in the request cycle, so it is decoded from the
    // current state and live handshakes rather than registered.
    assign stall = ((state_q == MW_IDLE) && req && !data_ok) ||
                   ((state_q == MW_WAIT) && !data_ok);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignment for state; blocking here would race
        // with other clocked readers.
        if (rst) state_q <= MW_IDLE;
        else     state_q <= state_d;
    end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Hazard, stall and flush controller for the 5-stage MIPS pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   hz       : hazard_unit_if.slave carrying register numbers, stage control,
//              instruction/data handshakes, exceptionM (inputs) and
//              forwardAD/BD/AE/BE, stallF..W, flushD..W (outputs)
// Forwarding, load-use/branch/divide stalls, long-latency memory stalls and
// exception flush sequencing. An exception seen while a memory transaction is
// outstanding is held in except_pend and fired once the transaction ends.
// Priority: except_fire > long > divstall > lwstall/brstall.
// -----------------------------------------------------------------------------
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    localparam logic [REGW-1:0] R0 = '0;

    logic [1:0] fwd_ae, fwd_be;
    logic       i_stall, d_stall;
    logic       long_stall, lwstall, brstall, divstall;
    logic       except_pend_q, except_pend_d, except_fire;
    logic       e_hits_d, m_hits_d;

    // ---------------- forwarding (register 0 never forwarded) ----------------
    always_comb begin
        fwd_ae = FWD_RF;
        if (hz.regwriteM && hz.writeregM != R0 && hz.writeregM == hz.rsE)
            fwd_ae = FWD_M;
        else if (hz.regwriteW && hz.writeregW != R0 && hz.writeregW == hz.rsE)
            fwd_ae = FWD_W;

        fwd_be = FWD_RF;
        if (hz.regwriteM && hz.writeregM != R0 && hz.writeregM == hz.rtE)
            fwd_be = FWD_M;
        else if (hz.regwriteW && hz.writeregW != R0 && hz.writeregW == hz.rtE)
            fwd_be = FWD_W;
    end

    assign hz.forwardAE = fwd_ae;
    assign hz.forwardBE = fwd_be;
    assign hz.forwardAD = hz.regwriteM && hz.writeregM != R0 && hz.writeregM == hz.rsD;
    assign hz.forwardBD = hz.regwriteM && hz.writeregM != R0 && hz.writeregM == hz.rtD;

    // ---------------- outstanding memory transactions ----------------
    mem_wait_fsm u_inst_fsm (
        .clk     (clk),
        .rst     (rst),
        .req     (hz.inst_req),
        .addr_ok (hz.inst_addr_ok),
        .data_ok (hz.inst_data_ok),
        .stall   (i_stall)
    );

    mem_wait_fsm u_data_fsm (
        .clk     (clk),
        .rst     (rst),
        .req     (hz.data_req),
        .addr_ok (hz.data_addr_ok),
        .data_ok (hz.data_data_ok),
        .stall   (d_stall)
    );

    assign long_stall = i_stall || d_stall;

    // ---------------- data-hazard stalls ----------------
    assign lwstall = hz.memtoregE && hz.writeregE != R0 &&
                     (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD);

    // A branch/jr in D compares in D, so a result still in E (any ALU op) or a
    // load result still in M cannot be forwarded in time.
    assign e_hits_d = hz.regwriteE && hz.writeregE != R0 &&
                      (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD);
    assign m_hits_d = hz.memtoregM && hz.writeregM != R0 &&
                      (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD);
    assign brstall  = (hz.branchD || hz.jrD) && (e_hits_d || m_hits_d);

    assign divstall = hz.div_busyE && !hz.div_readyE;

    // ---------------- exception sequencing ----------------
    // An exception during a memory wait cannot flush yet: the bridge still owes
    // a response. Remember it until the wait ends, then fire.
    always_comb begin
        except_pend_d = 1'b0;
        if (long_stall) except_pend_d = except_pend_q || hz.exceptionM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) except_pend_q <= 1'b0;
        else     except_pend_q <= except_pend_d;
    end

    assign except_fire = (hz.exceptionM || except_pend_q) && !long_stall;

    // ---------------- stall / flush outputs ----------------
    assign hz.stallF = (long_stall || lwstall || brstall || divstall) && !except_fire;
    assign hz.stallD = hz.stallF;
    assign hz.stallE = long_stall || divstall;
    assign hz.stallM = long_stall;
    assign hz.stallW = long_stall;

    assign hz.flushD = except_fire;
    assign hz.flushE = except_fire || ((lwstall || brstall) && !divstall && !long_stall);
    // Bubble into M behind a divide held in E.
    assign hz.flushM = except_fire || (divstall && !long_stall);
    // W holds the oldest instruction; it always commits.
    assign hz.flushW = 1'b0;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Directed vectors for hazard_unit. Inputs change 1 ns after the rising edge;
// outputs are compared 2 ns later, well before the next edge.
// Observed/expected vector layout:
//   {0, forwardAD, forwardBD, forwardAE[1:0], forwardBE[1:0],
//    stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW}
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_unit_if #(.REGW(5)) hif ();

    hazard_unit #(.REGW(5)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] obs;
    assign obs = {1'b0, hif.forwardAD, hif.forwardBD, hif.forwardAE, hif.forwardBE,
                  hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.stallW,
                  hif.flushD, hif.flushE, hif.flushM, hif.flushW};

    // st = {F,D,E,M,W}, fl = {D,E,M,W}
    function automatic logic [15:0] mk(input logic fad, input logic fbd,
                                       input logic [1:0] fae, input logic [1:0] fbe,
                                       input logic [4:0] st, input logic [3:0] fl);
        return {1'b0, fad, fbd, fae, fbe, st, fl};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
        hif.writeregE = '0; hif.writeregM = '0; hif.writeregW = '0;
        hif.regwriteE = 0; hif.regwriteM = 0; hif.regwriteW = 0;
        hif.memtoregE = 0; hif.memtoregM = 0;
        hif.branchD = 0; hif.jrD = 0;
        hif.div_busyE = 0; hif.div_readyE = 0;
        hif.inst_req = 0; hif.inst_addr_ok = 0; hif.inst_data_ok = 0;
        hif.data_req = 0; hif.data_addr_ok = 0; hif.data_data_ok = 0;
        hif.exceptionM = 0;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check(input string tag, input logic [15:0] exp);
        #2;
        check(tag, obs, exp);
    endtask

    localparam logic [4:0] ST_ALL = 5'b11111;
    localparam logic [4:0] ST_FD  = 5'b11000;
    localparam logic [4:0] ST_FDE = 5'b11100;
    localparam logic [3:0] FL_E   = 4'b0100;
    localparam logic [3:0] FL_M   = 4'b0010;
    localparam logic [3:0] FL_EXC = 4'b1110;

    initial begin
        clear_inputs();
        next();
        settle_check("reset_all_zero", 16'h0000);
        next();
        rst = 1'b0;
        next();
        settle_check("idle_all_zero", 16'h0000);

        // ---------------- forwarding ----------------
        hif.regwriteM = 1; hif.writeregM = 5'd8;
        hif.regwriteW = 1; hif.writeregW = 5'd8;
        hif.rsE = 5'd8;
        settle_check("fwd_ae_from_m", mk(0, 0, 2'b10, 2'b00, 5'b0, 4'b0));
        hif.writeregM = 5'd0;
        settle_check("fwd_ae_from_w", mk(0, 0, 2'b01, 2'b00, 5'b0, 4'b0));
        hif.writeregM = 5'd8; hif.rtE = 5'd8; hif.rsD = 5'd8;
        settle_check("fwd_m_ae_be_ad", mk(1, 0, 2'b10, 2'b10, 5'b0, 4'b0));
        hif.regwriteM = 0; hif.rtD = 5'd8;
        settle_check("fwd_w_only", mk(0, 0, 2'b01, 2'b01, 5'b0, 4'b0));
        hif.regwriteM = 1; hif.writeregM = 5'd0; hif.regwriteW = 1; hif.writeregW = 5'd0;
        hif.rsE = 5'd0; hif.rtE = 5'd0; hif.rsD = 5'd0; hif.rtD = 5'd0;
        settle_check("fwd_r0_never", 16'h0000);
        clear_inputs();

        // ---------------- load-use ----------------
        next();
        hif.memtoregE = 1; hif.writeregE = 5'd9; hif.rtD = 5'd9;
        settle_check("lwstall", mk(0, 0, 2'b00, 2'b00, ST_FD, FL_E));
        next();
        hif.memtoregE = 0;
        settle_check("lwstall_clear", 16'h0000);
        hif.memtoregE = 1; hif.writeregE = 5'd0; hif.rtD = 5'd0;
        settle_check("lwstall_r0", 16'h0000);
        clear_inputs();

        // ---------------- branch stalls ----------------
        hif.branchD = 1; hif.regwriteE = 1; hif.writeregE = 5'd5; hif.rsD = 5'd5;
        settle_check("brstall_e", mk(0, 0, 2'b00, 2'b00, ST_FD, FL_E));
        clear_inputs();
        hif.jrD = 1; hif.memtoregM = 1; hif.writeregM = 5'd6; hif.rtD = 5'd6;
        settle_check("brstall_m_load", mk(0, 0, 2'b00, 2'b00, ST_FD, FL_E));
        hif.jrD = 0;
        settle_check("no_branch_no_stall", 16'h0000);
        clear_inputs();

        // ---------------- divide ----------------
        for (int i = 0; i < 4; i++) begin
            next();
            hif.div_busyE = 1; hif.div_readyE = 0;
            settle_check($sformatf("div_busy_%0d", i), mk(0, 0, 2'b00, 2'b00, ST_FDE, FL_M));
        end
        next();
        hif.div_readyE = 1;
        settle_check("div_ready", 16'h0000);
        hif.div_readyE = 0;
        hif.memtoregE = 1; hif.writeregE = 5'd3; hif.rsD = 5'd3;
        settle_check("div_over_lwstall", mk(0, 0, 2'b00, 2'b00, ST_FDE, FL_M));
        clear_inputs();

        // ---------------- fetch wait ----------------
        next();
        hif.inst_req = 1; hif.inst_addr_ok = 1;
        settle_check("fetch_t0", mk(0, 0, 2'b00, 2'b00, ST_ALL, 4'b0));
        next();
        hif.inst_req = 0; hif.inst_addr_ok = 0;
        settle_check("fetch_t1_wait", mk(0, 0, 2'b00, 2'b00, ST_ALL, 4'b0));
        next();
        settle_check("fetch_t2_wait", mk(0, 0, 2'b00, 2'b00, ST_ALL, 4'b0));
        next();
        hif.inst_data_ok = 1;
        settle_check("fetch_t3_done", 16'h0000);
        next();
        hif.inst_data_ok = 0;
        settle_check("fetch_t4_idle", 16'h0000);
        // Zero-wait access: data_ok with addr_ok
        hif.inst_req = 1; hif.inst_addr_ok = 1; hif.inst_data_ok = 1;
        settle_check("fetch_zero_wait", 16'h0000);
        next();
        clear_inputs();
        settle_check("fetch_zero_wait_after", 16'h0000);

        // ---------------- exception during data wait ----------------
        next();
        hif.data_req = 1; hif.data_addr_ok = 1;
        settle_check("exc_t0", mk(0, 0, 2'b00, 2'b00, ST_ALL, 4'b0));
        next();
        hif.data_req = 0; hif.data_addr_ok = 0; hif.exceptionM = 1;
        settle_check("exc_t1_held", mk(0, 0, 2'b00, 2'b00, ST_ALL, 4'b0));
        next();
        hif.exceptionM = 0;
        settle_check("exc_t2_pend", mk(0, 0, 2'b00, 2'b00, ST_ALL, 4'b0));
        next();
        settle_check("exc_t3_pend", mk(0, 0, 2'b00, 2'b00, ST_ALL, 4'b0));
        next();
        hif.data_data_ok = 1;
        settle_check("exc_t4_fire", mk(0, 0, 2'b00, 2'b00, 5'b0, FL_EXC));
        next();
        hif.data_data_ok = 0;
        settle_check("exc_t5_cleared", 16'h0000);
        hif.exceptionM = 1; hif.memtoregE = 1; hif.writeregE = 5'd4; hif.rsD = 5'd4;
        settle_check("exc_direct_over_lw", mk(0, 0, 2'b00, 2'b00, 5'b0, FL_EXC));
        clear_inputs();

        // ---------------- async reset mid-wait ----------------
        next();
        hif.inst_req = 1; hif.inst_addr_ok = 1;
        next();
        hif.inst_req = 0; hif.inst_addr_ok = 0;
        settle_check("rst_pre_wait", mk(0, 0, 2'b00, 2'b00, ST_ALL, 4'b0));
        rst = 1'b1;
        #1;
        check("rst_async_drop", obs, 16'h0000);
        next();
        rst = 1'b0;
        settle_check("rst_stays_idle", 16'h0000);
        next();
        hif.inst_data_ok = 1;
        settle_check("rst_spurious_data_ok", 16'h0000);
        next();
        hif.inst_data_ok = 0;
        settle_check("rst_after_spurious", 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard and stall/flush controller for the 5-stage MIPS core. It feeds the stall/flush inputs of the decode-stage controller and datapath pipeline registers. It resolves data hazards with forwarding, load-use and branch stalls, and multi-cycle divide stalls. It also tracks outstanding sram-like instruction and data transactions toward the AXI bridge, and sequences exception flushes around them.

Parameters:
REGW, 5, register-number width

Ports:
clk in 1 clock
rst in 1 asynchronous active-high reset
rsD,rtD,rsE,rtE in REGW each: source regs in D/E
writeregE,writeregM,writeregW in REGW each: destination regs
regwriteE,regwriteM,regwriteW,memtoregE,memtoregM in 1 each: stage control
branchD,jrD in 1 each: D needs operands for compare/jump
div_busyE,div_readyE in 1 each: divide in E; divider result valid
inst_req,inst_addr_ok,inst_data_ok in 1 each: fetch handshake
data_req,data_addr_ok,data_data_ok in 1 each: M-stage memory handshake
exceptionM in 1: exception/eret taken in M
forwardAD,forwardBD out 1 each: D compare operand from M
forwardAE,forwardBE out 2 each: 00 regfile, 01 from W, 10 from M
stallF,stallD,stallE,stallM,stallW out 1 each
flushD,flushE,flushM,flushW out 1 each

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset sets both FSMs to IDLE and clears except_pend. With all inputs 0, every output is 0.
- Forwarding is combinational. Register 0 is never forwarded.
  - forwardAE = 10 if regwriteM & writeregM==rsE.
  - Otherwise forwardAE = 01 if regwriteW & writeregW==rsE. Otherwise 00.
  - forwardBE is the same rule using rtE.
  - forwardAD = regwriteM & writeregM==rsD. forwardBD is the same rule using rtD.
- Instruction FSM, states I_IDLE and I_WAIT:
  - I_IDLE→I_WAIT when inst_req & inst_addr_ok & ~inst_data_ok.
  - I_WAIT→I_IDLE on inst_data_ok.
  - i_stall = (I_IDLE & inst_req & ~inst_data_ok) | (I_WAIT & ~inst_data_ok).
- Data FSM, states D_IDLE and D_WAIT: identical rules using data_*, giving d_stall.
- A data_ok in the same cycle as addr_ok completes the transaction with no wait state.
- Definitions:
  - long = i_stall | d_stall.
  - lwstall = memtoregE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
  - brstall = (branchD|jrD) & [(regwriteE & writeregE∈{rsD,rtD}, nonzero) | (memtoregM & writeregM∈{rsD,rtD}, nonzero)].
  - divstall = div_busyE & ~div_readyE.
- except_pend register:
  - Set when exceptionM & long.
  - Cleared on the cycle ~long.
  - except_fire = (exceptionM | except_pend) & ~long.
- Stall outputs:
  - stallF = stallD = long | lwstall | brstall | divstall, but forced 0 on except_fire.
  - stallE = long | divstall.
  - stallM = stallW = long.
- Flush outputs:
  - flushD = except_fire.
  - flushE = except_fire | ((lwstall|brstall) & ~divstall & ~long).
  - flushM = except_fire | (divstall & ~long), which inserts a bubble behind a stalled divide.
  - flushW = 0. The W instruction is older and always commits.
- Priority: except_fire > long > divstall > lwstall/brstall.
- The fetch returned in the cycle of except_fire is discarded by flushD. Upstream suppresses data_req for a faulting M instruction.
- Reset mid-transaction: FSMs return to IDLE immediately. A late data_ok arriving in IDLE with no req is ignored.

Decomposition:
- Shared package: FSM state encodings and the forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10.
- One sub-module is natural: mem_wait_fsm, instantiated twice (inst, data). Ports: clk, rst, req, addr_ok, data_ok, stall.

Test Plan:
- Forwarding: regwriteM=1, writeregM=8; regwriteW=1, writeregW=8; rsE=8 → forwardAE=10. Set writeregM=0 → forwardAE=01.
- Load-use: memtoregE=1, writeregE=9, rtD=9 → stallF=stallD=flushE=1, stallE=0 for one cycle. Clear memtoregE → all 0.
- Divide: div_busyE=1 for 5 cycles, div_readyE on the 5th → stallE=flushM=1 for 4 cycles, then 0 on the ready cycle.
- Fetch wait: inst_req+inst_addr_ok at t0, inst_data_ok at t3 → stallF..stallW=1 at t0–t2, 0 at t3; FSM in I_WAIT t1–t2.
- Exception during data wait: d_stall active, exceptionM pulses 1 cycle at t1, data_data_ok at t4 → except_pend=1 t2–t4; flushD=flushE=flushM=1 only at t4; stall outputs 0 at t4.
- Async reset mid-I_WAIT: assert rst between edges → i_stall drops immediately. A spurious inst_data_ok afterwards → no stall, state stays I_IDLE.
